// File: rtl/mseq_word_gen.sv
// mseq_word_gen: Fibonacci LFSR m-sequence packed MSB-first into words.
// Ports: clk, rst (sync high), calcu_ctrl, seed_load/seed_in, m_data/m_valid/m_ready, period_done, word_cnt.
module mseq_word_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int LFSR_N = 7,
  parameter logic [LFSR_N-1:0] TAPS = 7'h60,
  parameter logic [LFSR_N-1:0] SEED = 7'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calcu_ctrl,
  input  logic                  seed_load,
  input  logic [LFSR_N-1:0]     seed_in,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  period_done,
  output logic [15:0]           word_cnt
);

  localparam int BCW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [LFSR_N-1:0] PC_LAST =
    {{(LFSR_N-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  state_t                state;
  logic [LFSR_N-1:0]     s;
  logic [DATA_WIDTH-1:0] pk;
  logic [BCW-1:0]        bc;
  logic [LFSR_N-1:0]     pc;

  logic                  fb;
  logic [LFSR_N-1:0]     s_step;
  logic [LFSR_N-1:0]     s_next;
  logic [LFSR_N-1:0]     seed_val;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_last;
  logic                  free;
  logic                  accept;
  logic                  want;
  logic                  adv;
  logic                  stall_next;

  assign fb       = ^(s & TAPS);
  assign s_step   = {s[LFSR_N-2:0], fb};
  // Guard against an all-zero state with degenerate tap masks.
  assign s_next   = (s_step == '0) ? SEED : s_step;
  assign seed_val = (seed_in == '0) ? SEED : seed_in;
  assign word     = {pk[DATA_WIDTH-2:0], s[LFSR_N-1]};

  assign word_last = (bc == BC_LAST);
  assign free      = !m_valid || m_ready;
  assign accept    = m_valid && m_ready;
  // A stalled word completes on the first free cycle.
  assign want       = calcu_ctrl || (state == STALL);
  assign adv        = !seed_load && want && (!word_last || free);
  assign stall_next = want && word_last && !free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s           <= SEED;
      pk          <= '0;
      bc          <= '0;
      pc          <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      period_done <= 1'b0;
      word_cnt    <= '0;
    end else begin
      period_done <= 1'b0;

      if (seed_load) begin
        state <= IDLE;
        s     <= seed_val;
        pk    <= '0;
        bc    <= '0;
        pc    <= '0;
      end else begin
        unique case (1'b1)
          stall_next:               state <= STALL;
          calcu_ctrl && !stall_next: state <= RUN;
          default:                  state <= IDLE;
        endcase
      end

      if (adv) begin
        s  <= s_next;
        pk <= word;
        bc <= word_last ? '0 : bc + 1'b1;
        pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
        period_done <= (pc == PC_LAST);
      end

      if (adv && word_last) begin
        m_data  <= word;
        m_valid <= 1'b1;
      end else if (accept) begin
        m_valid <= 1'b0;
      end

      if (accept) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule
